// File: rtl/var_bw_mul_acc.sv
// var_bw_mul_acc: accumulates multiplier products into a 40-bit result.
// Mode 0 sums one 32-bit product per beat into a single 40-bit lane.
// Mode 1 sums two packed 16-bit products per beat into two independent
// 20-bit lanes. A block ends on in_last. The result is then held until the
// consumer takes it.
module var_bw_mul_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_para_mode,
    input  logic [31:0] in_p,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_para_mode,
    output logic [39:0] out_acc,
    output logic [7:0]  out_count,
    output logic        out_ovf,
    output logic        out_mode_err
);

    localparam int ACC_W  = 40;
    localparam int LANE_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    logic               mode;
    logic [ACC_W-1:0]   acc;
    logic [7:0]         count;
    logic               ovf;
    logic               mode_err;

    logic [ACC_W-1:0]   add_base;
    logic               add_mode;
    logic [ACC_W:0]     add_res;
    logic               accept;

    // Adds one beat to the accumulator. Bit 40 of the result flags a wrap:
    // the carry out of bit 39 in mode 0, or the carry out of either lane in
    // mode 1. The two lanes never carry into each other.
    function automatic logic [ACC_W:0] add_contrib(input logic [ACC_W-1:0] a,
                                                   input logic [31:0]      p,
                                                   input logic             m);
        logic [ACC_W:0]  wide;
        logic [LANE_W:0] hi;
        logic [LANE_W:0] lo;
        if (m == 1'b0) begin
            wide = {1'b0, a} + {9'b0, p};
        end else begin
            hi   = {1'b0, a[ACC_W-1:LANE_W]} + {5'b0, p[31:16]};
            lo   = {1'b0, a[LANE_W-1:0]}     + {5'b0, p[15:0]};
            wide = {hi[LANE_W] | lo[LANE_W], hi[LANE_W-1:0], lo[LANE_W-1:0]};
        end
        return wide;
    endfunction

    // The beat counter stops at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign accept        = in_valid && in_ready;
    assign in_ready      = (state != HOLD);
    assign out_valid     = (state == HOLD);
    assign out_para_mode = mode;
    assign out_acc       = acc;
    assign out_count     = count;
    assign out_ovf       = ovf;
    assign out_mode_err  = mode_err;

    // The first beat of a block starts from zero using the incoming mode.
    // Later beats add onto the running sum using the latched block mode.
    always_comb begin
        add_base = (state == IDLE) ? '0 : acc;
        add_mode = (state == IDLE) ? in_para_mode : mode;
        add_res  = add_contrib(add_base, in_p, add_mode);
    end

    // Block FSM and the accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode     <= 1'b0;
            acc      <= '0;
            count    <= 8'd0;
            ovf      <= 1'b0;
            mode_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode     <= in_para_mode;
                        acc      <= add_res[ACC_W-1:0];
                        ovf      <= add_res[ACC_W];
                        count    <= 8'd1;
                        mode_err <= 1'b0;
                        state    <= in_last ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (in_para_mode == mode) begin
                            acc   <= add_res[ACC_W-1:0];
                            ovf   <= ovf | add_res[ACC_W];
                            count <= sat_inc(count);
                        end else begin
                            // A beat with the wrong mode is dropped and flagged.
                            // It still ends the block when it carries in_last.
                            mode_err <= 1'b1;
                        end
                        if (in_last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state    <= IDLE;
                        mode     <= 1'b0;
                        acc      <= '0;
                        count    <= 8'd0;
                        ovf      <= 1'b0;
                        mode_err <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_var_bw_mul_acc.sv
// Testbench for var_bw_mul_acc. It runs directed cases and randomized
// blocks, and compares the DUT against an arithmetic reference model.
module tb_var_bw_mul_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_para_mode;
    logic [31:0] in_p;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic        out_para_mode;
    logic [39:0] out_acc;
    logic [7:0]  out_count;
    logic        out_ovf;
    logic        out_mode_err;

    int errors = 0;
    int checks = 0;

    // Reference model state for the block currently being accumulated
    bit              m_open;
    bit              m_mode;
    longint unsigned m_sum;
    longint unsigned m_hi;
    longint unsigned m_lo;
    int              m_cnt;
    bit              m_ovf;
    bit              m_err;

    localparam longint unsigned TWO40 = 64'h100_0000_0000;
    localparam longint unsigned TWO20 = 64'h10_0000;

    always #5 clk = ~clk;

    var_bw_mul_acc dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_para_mode (in_para_mode),
        .in_p         (in_p),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_para_mode(out_para_mode),
        .out_acc      (out_acc),
        .out_count    (out_count),
        .out_ovf      (out_ovf),
        .out_mode_err (out_mode_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m_open = 0; m_mode = 0; m_sum = 0; m_hi = 0; m_lo = 0;
        m_cnt = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic m_beat(input bit m, input logic [31:0] p);
        bit add;
        add = 0;
        if (!m_open) begin
            m_open = 1;
            m_mode = m;
            add    = 1;
        end else if (m != m_mode) begin
            m_err = 1;
        end else begin
            add = 1;
        end
        if (add) begin
            if (m_cnt < 255) m_cnt++;
            if (m_mode == 0) begin
                m_sum = m_sum + longint'(p);
                if (m_sum >= TWO40) begin m_sum = m_sum - TWO40; m_ovf = 1; end
            end else begin
                m_hi = m_hi + longint'(p[31:16]);
                m_lo = m_lo + longint'(p[15:0]);
                if (m_hi >= TWO20) begin m_hi = m_hi - TWO20; m_ovf = 1; end
                if (m_lo >= TWO20) begin m_lo = m_lo - TWO20; m_ovf = 1; end
            end
        end
    endtask

    function automatic logic [39:0] m_acc();
        logic [39:0] r;
        if (m_mode == 0) r = m_sum[39:0];
        else             r = {m_hi[19:0], m_lo[19:0]};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat. Wait (bounded) for in_ready, then hold the beat through one edge.
    task automatic send(input bit m, input logic [31:0] p, input bit l);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        if (n == 50) chk("in_ready_timeout", 0, 1);
        in_valid = 1; in_para_mode = m; in_p = p; in_last = l;
        step();
        in_valid = 0; in_last = 0;
        m_beat(m, p);
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_acc"},   out_acc,       m_acc());
        chk({tag, "_count"}, out_count,     m_cnt);
        chk({tag, "_mode"},  out_para_mode, m_mode);
        chk({tag, "_ovf"},   out_ovf,       m_ovf);
        chk({tag, "_err"},   out_mode_err,  m_err);
    endtask

    // Call right after the last beat. During the stall, a beat held on the
    // input port must be ignored.
    task automatic take_result(input string tag, input int stall);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_ready_lo"}, in_ready, 0);
        check_fields(tag);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1; in_p = $urandom; in_para_mode = $urandom_range(0, 1);
            step();
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_ready"}, in_ready, 0);
            chk({tag, "_stall_acc"},   out_acc, m_acc());
            chk({tag, "_stall_cnt"},   out_count, m_cnt);
        end
        in_valid  = 0;
        out_ready = 1;
        step();
        out_ready = 0;
        chk({tag, "_rel_valid"}, out_valid, 0);
        chk({tag, "_rel_ready"}, in_ready, 1);
        chk({tag, "_rel_count"}, out_count, 0);
        m_clear();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, out_valid,     0);
        chk({tag, "_ready"}, in_ready,      1);
        chk({tag, "_acc"},   out_acc,       0);
        chk({tag, "_count"}, out_count,     0);
        chk({tag, "_mode"},  out_para_mode, 0);
        chk({tag, "_ovf"},   out_ovf,       0);
        chk({tag, "_err"},   out_mode_err,  0);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_para_mode = 0; in_p = 0; in_last = 0; out_ready = 0;
        m_clear();
        step(); step();
        rst = 0;
        check_reset_state("reset");

        // Mode 0: two small beats
        send(0, 32'h10, 0);
        send(0, 32'h20, 1);
        chk("m0_acc_const", out_acc, 40'h30);
        take_result("m0", 0);

        // Mode 1: each lane wraps past 16 bits but stays below 20 bits
        send(1, 32'hFFFF_FFFF, 0);
        send(1, 32'hFFFF_FFFF, 1);
        chk("m1_acc_const", out_acc, {20'h1FFFE, 20'h1FFFE});
        take_result("m1", 2);

        // Mode 0 wraps past 40 bits and the count saturates
        for (int i = 0; i < 257; i++) send(0, 32'hFFFF_FFFF, i == 256);
        chk("sat_acc_const", out_acc, 40'h00FF_FFFE_FF);
        chk("sat_cnt_const", out_count, 8'd255);
        chk("sat_ovf_const", out_ovf, 1);
        take_result("sat", 0);

        // The result must stay put while the consumer stalls
        send(0, 32'h1234, 1);
        take_result("stall5", 5);

        // A beat with the wrong mode is dropped but still closes the block
        send(1, 32'h0002_0003, 0);
        send(0, 32'h0000_0100, 1);
        chk("merr_acc_const", out_acc, {20'h2, 20'h3});
        chk("merr_cnt_const", out_count, 1);
        chk("merr_flag_const", out_mode_err, 1);
        take_result("merr", 1);

        // Reset in the middle of a block, with a beat arriving at the same edge
        send(0, 32'h7, 0);
        send(0, 32'h8, 0);
        send(0, 32'h9, 0);
        rst = 1; in_valid = 1; in_p = 32'hABC; in_last = 1;
        step();
        rst = 0; in_valid = 0; in_last = 0;
        m_clear();
        check_reset_state("midrst");
        send(0, 32'h5, 1);
        chk("post_rst_acc", out_acc, 40'h5);
        chk("post_rst_cnt", out_count, 1);
        take_result("post_rst", 0);

        // Randomized blocks with idle gaps, mode mismatches and stalls
        for (int b = 0; b < 40; b++) begin
            bit          bm;
            bit          mm;
            int          nb;
            logic [31:0] p;
            bm = $urandom_range(0, 1);
            nb = $urandom_range(1, 8);
            for (int i = 0; i < nb; i++) begin
                mm = (i > 0 && $urandom_range(0, 7) == 0) ? ~bm : bm;
                p  = ($urandom_range(0, 1) == 1) ? ($urandom | 32'hF000_F000) : $urandom;
                repeat ($urandom_range(0, 2)) step();
                send(mm, p, i == nb - 1);
            end
            take_result("rand", $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
